// File: rtl/pong_pkg.sv
// Shared definitions for the pong match controller: bounce event codes,
// controller state encoding, winner encoding and a saturating score helper.
package pong_pkg;

  // Event codes reported by GameLogic on the bounce bus
  localparam logic [1:0] NONE   = 2'd0;
  localparam logic [1:0] PADDLE = 2'd1;
  localparam logic [1:0] WALL   = 2'd2;
  localparam logic [1:0] POINT  = 2'd3;

  // Match FSM states; encodings fixed to match the legacy register values
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  // Winner output encoding
  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2
  } winner_t;

  // Score increment that sticks at 15 instead of wrapping
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/match_controller_if.sv
// Signal bundle between GameLogic/video side (master) and the match
// controller (slave).
interface match_controller_if;
  logic       frame_tick;
  logic       start;
  logic [1:0] bounce;
  logic       ball_run;
  logic       ball_reset;
  logic       dir_x;
  logic       dir_y;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       game_over;
  logic [1:0] winner;
  logic [2:0] speed;

  modport master (
    output frame_tick, start, bounce,
    input  ball_run, ball_reset, dir_x, dir_y, score_p1, score_p2,
           game_over, winner, speed
  );

  modport slave (
    input  frame_tick, start, bounce,
    output ball_run, ball_reset, dir_x, dir_y, score_p1, score_p2,
           game_over, winner, speed
  );
endinterface

// File: rtl/match_controller_bounce_filter.sv
// bounce_filter: accepts bounce events only on a change of code while
// enabled; paddle/wall events are further masked by a frame-counted holdoff,
// point events bypass the holdoff.
module bounce_filter
  import pong_pkg::*;
#(
  parameter int unsigned HOLDOFF_FRAMES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic [1:0] bounce,
  output logic       acc_paddle,
  output logic       acc_wall,
  output logic       acc_point
);

  localparam int unsigned HW = (HOLDOFF_FRAMES < 1) ? 1 : $clog2(HOLDOFF_FRAMES + 1);

  logic [1:0]    prev;
  logic [HW-1:0] holdoff;
  logic          rise;

  // Event qualification: new non-zero code while enabled
  always_comb begin
    rise       = enable && (bounce != NONE) && (bounce != prev);
    acc_point  = rise && (bounce == POINT);
    acc_paddle = rise && (bounce == PADDLE) && (holdoff == '0);
    acc_wall   = rise && (bounce == WALL) && (holdoff == '0);
  end

  // Previous-code register and holdoff down-counter
  always_ff @(posedge clock) begin
    if (reset) begin
      prev    <= NONE;
      holdoff <= '0;
    end else begin
      prev <= bounce;
      if (acc_paddle || acc_wall)
        holdoff <= HW'(HOLDOFF_FRAMES);
      else if (frame_tick && (holdoff != '0))
        holdoff <= holdoff - 1'b1;
    end
  end

endmodule

// File: rtl/match_controller.sv
// match_controller: pong match sequencing (idle, serve delay, rally, point
// scoring, game over), score keeping and ball direction control.
// Optional feature macro: PONG_SPEEDUP_EN (ball speed-up every 4th paddle hit).
module match_controller
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE      = 9,
  parameter int unsigned SERVE_FRAMES   = 60,
  parameter int unsigned HOLDOFF_FRAMES = 2
) (
  input  logic              clock,
  input  logic              reset,
  match_controller_if.slave bus
);

  localparam int unsigned SW = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES);

  state_t        state, state_nx;
  logic [SW-1:0] serve_cnt;
  logic          last_p1;
  logic [3:0]    scorer_score;
  logic          enter_serve;
  logic          restart;
  logic          acc_paddle, acc_wall, acc_point;

  logic          ball_run_q, ball_reset_q, dir_x_q, dir_y_q, game_over_q;
  logic [3:0]    p1_q, p2_q;
  logic [1:0]    winner_q;

  bounce_filter #(.HOLDOFF_FRAMES(HOLDOFF_FRAMES)) u_filter (
    .clock      (clock),
    .reset      (reset),
    .enable     (state == S_PLAY),
    .frame_tick (bus.frame_tick),
    .bounce     (bus.bounce),
    .acc_paddle (acc_paddle),
    .acc_wall   (acc_wall),
    .acc_point  (acc_point)
  );

  // Next-state decode; outputs are registered from the next state so they
  // line up with the state register
  always_comb begin
    state_nx     = state;
    scorer_score = last_p1 ? p1_q : p2_q;
    restart      = bus.start && ((state == S_IDLE) || (state == S_OVER));
    case (state)
      S_IDLE:  if (bus.start) state_nx = S_SERVE;
      S_SERVE: if (bus.frame_tick && (serve_cnt == SW'(SERVE_FRAMES - 1))) state_nx = S_PLAY;
      S_PLAY:  if (acc_point) state_nx = S_POINT;
      S_POINT: state_nx = (scorer_score == 4'(WIN_SCORE)) ? S_OVER : S_SERVE;
      S_OVER:  if (bus.start) state_nx = S_SERVE;
      default: state_nx = S_IDLE;
    endcase
    enter_serve = (state_nx == S_SERVE) && (state != S_SERVE);
  end

  // State, serve delay, scores, directions and status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      serve_cnt    <= '0;
      last_p1      <= 1'b1;
      p1_q         <= '0;
      p2_q         <= '0;
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      ball_run_q   <= 1'b0;
      ball_reset_q <= 1'b1;
      game_over_q  <= 1'b0;
      winner_q     <= WIN_NONE;
    end else begin
      state        <= state_nx;
      ball_run_q   <= (state_nx == S_PLAY);
      ball_reset_q <= (state_nx == S_IDLE) || (state_nx == S_SERVE) || (state_nx == S_OVER);
      game_over_q  <= (state_nx == S_OVER);

      if (enter_serve)
        serve_cnt <= '0;
      else if ((state == S_SERVE) && bus.frame_tick)
        serve_cnt <= serve_cnt + 1'b1;

      if (restart) begin
        p1_q     <= '0;
        p2_q     <= '0;
        winner_q <= WIN_NONE;
      end

      if (enter_serve)
        dir_y_q <= 1'b1;

      if (acc_point) begin
        last_p1 <= dir_x_q;
        if (dir_x_q) p1_q <= sat_inc4(p1_q);
        else         p2_q <= sat_inc4(p2_q);
      end else if (acc_paddle) begin
        dir_x_q <= ~dir_x_q;
      end else if (acc_wall) begin
        dir_y_q <= ~dir_y_q;
      end

      if ((state == S_POINT) && (state_nx == S_OVER))
        winner_q <= last_p1 ? WIN_P1 : WIN_P2;
    end
  end

`ifdef PONG_SPEEDUP_EN
  logic [1:0] hits;
  logic [2:0] speed_q;

  // Rally speed-up: one step per 4 accepted paddle hits, reset on each serve
  always_ff @(posedge clock) begin
    if (reset) begin
      hits    <= '0;
      speed_q <= 3'd1;
    end else if (enter_serve) begin
      hits    <= '0;
      speed_q <= 3'd1;
    end else if (acc_paddle) begin
      hits <= hits + 2'd1;
      if ((hits == 2'd3) && (speed_q != 3'd7))
        speed_q <= speed_q + 3'd1;
    end
  end

  assign bus.speed = speed_q;
`else
  assign bus.speed = 3'd1;
`endif

  assign bus.ball_run   = ball_run_q;
  assign bus.ball_reset = ball_reset_q;
  assign bus.dir_x      = dir_x_q;
  assign bus.dir_y      = dir_y_q;
  assign bus.score_p1   = p1_q;
  assign bus.score_p2   = p2_q;
  assign bus.game_over  = game_over_q;
  assign bus.winner     = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: directed table, directed
// multi-cycle sequences and random stimulus against a behavioural game model.
module tb_match_controller;

  localparam int WIN   = 9;
  localparam int SERVE = 60;
  localparam int HOLD  = 2;

  localparam int PH_IDLE  = 0;
  localparam int PH_SERVE = 1;
  localparam int PH_PLAY  = 2;
  localparam int PH_POINT = 3;
  localparam int PH_OVER  = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  match_controller_if bus();

  match_controller #(
    .WIN_SCORE      (WIN),
    .SERVE_FRAMES   (SERVE),
    .HOLDOFF_FRAMES (HOLD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Behavioural game model
  int m_phase, m_served, m_hold, m_prev, m_p1, m_p2, m_win, m_scorer;
  int m_dx, m_dy, m_speed, m_hits;

  task automatic model_step(input bit r, input bit st, input bit tk, input int b);
    int  nphase;
    bit  loaded;
    bit  is_edge;
    int  total;
    if (r) begin
      m_phase = PH_IDLE; m_served = 0; m_hold = 0; m_prev = 0;
      m_p1 = 0; m_p2 = 0; m_win = 0; m_scorer = 1;
      m_dx = 1; m_dy = 1; m_speed = 1; m_hits = 0;
      return;
    end
    nphase = m_phase;
    loaded = 0;
    case (m_phase)
      PH_IDLE, PH_OVER: if (st) begin
        m_p1 = 0; m_p2 = 0; m_win = 0; nphase = PH_SERVE;
      end
      PH_SERVE: if (tk) begin
        m_served++;
        if (m_served == SERVE) nphase = PH_PLAY;
      end
      PH_PLAY: begin
        is_edge = (b != 0) && (b != m_prev);
        if (is_edge && b == 3) begin
          m_scorer = (m_dx == 1) ? 1 : 2;
          if (m_scorer == 1) m_p1 = (m_p1 < 15) ? m_p1 + 1 : 15;
          else               m_p2 = (m_p2 < 15) ? m_p2 + 1 : 15;
          nphase = PH_POINT;
        end else if (is_edge && m_hold == 0) begin
          if (b == 1) begin
            m_dx = 1 - m_dx;
            m_hits++;
`ifdef PONG_SPEEDUP_EN
            if (m_hits % 4 == 0 && m_speed < 7) m_speed++;
`endif
          end else begin
            m_dy = 1 - m_dy;
          end
          m_hold = HOLD;
          loaded = 1;
        end
      end
      PH_POINT: begin
        total = (m_scorer == 1) ? m_p1 : m_p2;
        if (total == WIN) begin
          nphase = PH_OVER; m_win = m_scorer;
        end else begin
          nphase = PH_SERVE;
        end
      end
      default: nphase = PH_IDLE;
    endcase
    if (!loaded && tk && m_hold > 0) m_hold--;
    if (nphase == PH_SERVE && m_phase != PH_SERVE) begin
      m_served = 0; m_dy = 1; m_speed = 1; m_hits = 0;
    end
    m_phase = nphase;
    m_prev  = b;
  endtask

  task automatic compare_model();
    logic [17:0] e, a;
    e = {m_phase == PH_PLAY,
         (m_phase == PH_IDLE) || (m_phase == PH_SERVE) || (m_phase == PH_OVER),
         1'(m_dx), 1'(m_dy), 4'(m_p1), 4'(m_p2), m_phase == PH_OVER,
         2'(m_win), 3'(m_speed)};
    a = {bus.ball_run, bus.ball_reset, bus.dir_x, bus.dir_y, bus.score_p1,
         bus.score_p2, bus.game_over, bus.winner, bus.speed};
    // ball_reset is not defined during the single point cycle
    if (m_phase == PH_POINT) begin
      e[16] = 1'b0;
      a[16] = 1'b0;
    end
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL model cyc=%0d got=%h exp=%h (run,rst,dx,dy,p1,p2,go,win,spd)", cyc, a, e);
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit st, input bit tk, input logic [1:0] b);
    reset          = r;
    bus.start      = st;
    bus.frame_tick = tk;
    bus.bounce     = b;
    @(posedge clock);
    #1;
    cyc++;
    model_step(r, st, tk, int'(b));
    compare_model();
  endtask

  task automatic serve60();
    for (int i = 0; i < SERVE; i++) begin
      if (i % 17 == 5) step(0, 0, 0, 2'd0);
      step(0, 0, 1, 2'd0);
      if (i == SERVE - 2) check("serve_pre_run", bus.ball_run, 0);
    end
    check("serve_play_run", bus.ball_run, 1);
    check("serve_play_rst", bus.ball_reset, 0);
  endtask

  task automatic score_point(input int who);
    serve60();
    if ((who == 1) != (m_dx == 1)) begin
      step(0, 0, 0, 2'd1);
      step(0, 0, 1, 2'd0);
      step(0, 0, 1, 2'd0);
    end
    step(0, 0, 0, 2'd3);
    step(0, 0, 0, 2'd0);
  endtask

  typedef struct {
    bit         st;
    bit         tk;
    logic [1:0] b;
    bit         run;
    bit         chk_rst;
    bit         rst_o;
    bit         dx;
    bit         dy;
    int         p1;
    int         p2;
  } vec_t;

  function automatic vec_t mk(bit st, bit tk, logic [1:0] b, bit run, bit chk_rst,
                              bit rst_o, bit dx, bit dy, int p1, int p2);
    vec_t v;
    v.st = st; v.tk = tk; v.b = b; v.run = run; v.chk_rst = chk_rst;
    v.rst_o = rst_o; v.dx = dx; v.dy = dy; v.p1 = p1; v.p2 = p2;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    logic [1:0] rb;
    int         rr;

    // Rally vectors starting at the first PLAY cycle (dx=1, dy=1)
    tbl[0]  = mk(0, 0, 2'd1, 1, 1, 0, 0, 1, 0, 0); // paddle edge toggles dx
    tbl[1]  = mk(0, 0, 2'd1, 1, 1, 0, 0, 1, 0, 0); // held: no retoggle
    tbl[2]  = mk(0, 0, 2'd1, 1, 1, 0, 0, 1, 0, 0);
    tbl[3]  = mk(0, 0, 2'd1, 1, 1, 0, 0, 1, 0, 0);
    tbl[4]  = mk(0, 0, 2'd1, 1, 1, 0, 0, 1, 0, 0);
    tbl[5]  = mk(0, 1, 2'd0, 1, 1, 0, 0, 1, 0, 0); // holdoff 2 -> 1
    tbl[6]  = mk(0, 0, 2'd2, 1, 1, 0, 0, 1, 0, 0); // wall during holdoff ignored
    tbl[7]  = mk(0, 1, 2'd0, 1, 1, 0, 0, 1, 0, 0); // holdoff 1 -> 0
    tbl[8]  = mk(0, 1, 2'd0, 1, 1, 0, 0, 1, 0, 0);
    tbl[9]  = mk(0, 0, 2'd2, 1, 1, 0, 0, 0, 0, 0); // wall accepted
    tbl[10] = mk(0, 1, 2'd0, 1, 1, 0, 0, 0, 0, 0);
    tbl[11] = mk(0, 1, 2'd0, 1, 1, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 2'd1, 1, 1, 0, 1, 0, 0, 0); // dx back to 1
    tbl[13] = mk(1, 0, 2'd0, 1, 1, 0, 1, 0, 0, 0); // start ignored in PLAY
    tbl[14] = mk(0, 0, 2'd3, 0, 0, 0, 1, 0, 1, 0); // point for P1, POINT cycle
    tbl[15] = mk(0, 0, 2'd0, 0, 1, 1, 1, 1, 1, 0); // SERVE, dy forced to 1

    reset = 1'b1; bus.start = 1'b0; bus.frame_tick = 1'b0; bus.bounce = 2'd0;

    // Reset state
    step(1, 0, 0, 2'd0);
    check("rst_run", bus.ball_run, 0);
    check("rst_ballrst", bus.ball_reset, 1);
    check("rst_dx", bus.dir_x, 1);
    check("rst_dy", bus.dir_y, 1);
    check("rst_go", bus.game_over, 0);
    check("rst_speed", bus.speed, 1);
    step(0, 0, 1, 2'd3);
    check("idle_hold", bus.ball_reset, 1);

    // Start, serve delay, PLAY
    step(0, 1, 0, 2'd0);
    check("start_serve_rst", bus.ball_reset, 1);
    check("start_serve_run", bus.ball_run, 0);
    serve60();
    check("play_dx", bus.dir_x, 1);

    // Table-driven rally and first point
    for (int i = 0; i < 16; i++) begin
      step(0, tbl[i].st, tbl[i].tk, tbl[i].b);
      check($sformatf("tbl%0d_run", i), bus.ball_run, tbl[i].run);
      if (tbl[i].chk_rst) check($sformatf("tbl%0d_rst", i), bus.ball_reset, tbl[i].rst_o);
      check($sformatf("tbl%0d_dx", i), bus.dir_x, tbl[i].dx);
      check($sformatf("tbl%0d_dy", i), bus.dir_y, tbl[i].dy);
      check($sformatf("tbl%0d_p1", i), bus.score_p1, tbl[i].p1);
      check($sformatf("tbl%0d_p2", i), bus.score_p2, tbl[i].p2);
    end

    // Player 2 to the winning score
    for (int k = 0; k < 8; k++) score_point(2);
    check("p2_eight", bus.score_p2, 8);
    check("p1_one", bus.score_p1, 1);
    serve60();
    check("final_dx", bus.dir_x, 0);
    step(0, 0, 0, 2'd3);
    check("final_p2", bus.score_p2, 9);
    check("final_point_run", bus.ball_run, 0);
    check("final_point_go", bus.game_over, 0);
    step(0, 0, 0, 2'd0);
    check("over_go", bus.game_over, 1);
    check("over_win", bus.winner, 2);
    check("over_rst", bus.ball_reset, 1);
    step(0, 0, 1, 2'd3);
    step(0, 0, 1, 2'd1);
    check("over_hold_p2", bus.score_p2, 9);
    check("over_hold_win", bus.winner, 2);
    step(0, 1, 0, 2'd0);
    check("restart_p1", bus.score_p1, 0);
    check("restart_p2", bus.score_p2, 0);
    check("restart_win", bus.winner, 0);
    check("restart_go", bus.game_over, 0);
    check("restart_rst", bus.ball_reset, 1);

    // Reset mid-serve, then start ignored in PLAY
    for (int i = 0; i < 30; i++) step(0, 0, 1, 2'd0);
    check("midserve_run", bus.ball_run, 0);
    step(1, 1, 1, 2'd3);
    check("midrst_run", bus.ball_run, 0);
    check("midrst_rst", bus.ball_reset, 1);
    check("midrst_dx", bus.dir_x, 1);
    check("midrst_go", bus.game_over, 0);
    step(0, 0, 1, 2'd0);
    check("midrst_idle", bus.ball_reset, 1);
    step(0, 1, 0, 2'd0);
    serve60();
    step(0, 1, 0, 2'd0);
    check("play_start_ignored", bus.ball_run, 1);

    // Eight separated paddle hits, then a point
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 2'd1);
      step(0, 0, 1, 2'd0);
      step(0, 0, 1, 2'd0);
    end
`ifdef PONG_SPEEDUP_EN
    check("speed_after_8", bus.speed, 3);
`else
    check("speed_after_8", bus.speed, 1);
`endif
    step(0, 0, 0, 2'd3);
    step(0, 0, 0, 2'd0);
    check("speed_after_point", bus.speed, 1);
    check("serve_after_point", bus.ball_reset, 1);

    // Random play against the model
    rb = 2'd0;
    for (int i = 0; i < 4000; i++) begin
      rr = int'($urandom_range(0, 15));
      if (rr < 10)       rb = 2'd0;
      else if (rr < 12)  rb = 2'd1;
      else if (rr < 14)  rb = 2'd2;
      else if (rr == 14) rb = 2'd3;
      step($urandom_range(0, 1499) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 1) == 1, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
